// File: rtl/md_seq_ctrl_pkg.sv
// Shared multiply/divide definitions: op encodings, controller states and
// default busy-window lengths, used by the controller, hazard unit and decoder.
package md_defs;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/md_seq_ctrl_arith.sv
// Combinational MULT/MULTU/DIV/DIVU datapath; result is {hi, lo}.
// Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
module md_arith
  import md_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // A zero divisor is replaced so the dividers never see zero; the result is discarded anyway.
  assign div_by_zero = (b == 32'd0);
  assign b_safe      = div_by_zero ? 32'd1 : b;

  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
  assign q_mag = abs_a / abs_b;
  assign r_mag = abs_a % abs_b;
  assign q_s   = (a[31] ^ b_safe[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = a[31] ? (~r_mag + 32'd1) : r_mag;

  assign q_u = a / b_safe;
  assign r_u = a % b_safe;

  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {r_s, q_s};
      MD_DIVU:  result = {r_u, q_u};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_seq_ctrl.sv
// Multiply/divide sequencing controller: owns HI/LO, runs a fixed busy window
// for MULT*/DIV*, and applies MTHI/MTLO directly when idle.
module md_seq_ctrl
  import md_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata,
  output md_state_e   state_dbg
);

  // Handshake: start is accepted only in IDLE with kill low; busy covers the
  // whole window and done pulses one cycle once HI/LO hold the new result.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [63:0]      result;
  logic             div_by_zero;
  logic             accept;

  md_arith u_arith (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  assign accept    = start && !kill;
  assign state_dbg = state;

  always_comb begin
    rdata = 32'd0;
    if (op == MD_MFHI) rdata = hi;
    else if (op == MD_MFLO) rdata = lo;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                op_q  <= op;
                a_q   <= rs_val;
                b_q   <= rt_val;
                cnt   <= (op == MD_MULT || op == MD_MULTU) ? MULT_LOAD : DIV_LOAD;
                busy  <= 1'b1;
                state <= ST_RUN;
              end
              MD_MTHI: hi <= rs_val;
              MD_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // New starts and kills are ignored here; the in-flight op already committed.
          if (cnt == '0) begin
            if (!(div_by_zero && (op_q == MD_DIV || op_q == MD_DIVU))) begin
              hi <= result[63:32];
              lo <= result[31:0];
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
